// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL layout, mode encodings and FSM states shared by
// the timer/counter and the CPU system bridge that decodes it.
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PSC_W  = 8;
    localparam int unsigned CTRL_W = 12;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_PSC_LSB  = 4;

    // MODE encodings; anything other than MODE_AUTO behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Device base addresses, also used by the bridge decoder
    localparam logic [DATA_W-1:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [DATA_W-1:0] TIMER1_BASE = 32'h0000_7F10;

    // CTRL register layout, LSB = EN
    typedef struct packed {
        logic [PSC_W-1:0] psc;
        logic             im;
        logic [1:0]       mode;
        logic             en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits a tick once every psc+1 cycles while not held in clear.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [PSC_W-1:0] psc,
    output logic             tick_c
);

    logic [PSC_W-1:0] div_cnt;

    assign tick_c = !clear && (div_cnt == psc);

    // Divider counter: restarts on clear and after every tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (clear || (div_cnt == psc)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot / auto-reload modes and
// a maskable interrupt. Optional prescaler enabled with macro TIMER_PRESCALE_EN.
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    ctrl_t            ctrl;
    ctrl_t            wr_ctrl_c;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_pend;
    state_t           state;

    logic ctrl_wr_c;
    logic preset_wr_c;
    logic auto_c;
    logic tick_c;
    logic irq_pend_nxt_c;
    logic im_nxt_c;
    logic unused_bits;

    assign ctrl_wr_c   = we && (addr[3:2] == ADDR_CTRL);
    assign preset_wr_c = we && (addr[3:2] == ADDR_PRESET);
    assign auto_c      = (ctrl.mode == MODE_AUTO);
    assign unused_bits = ^{addr[DATA_W-1:4], addr[1:0], wdata};

`ifdef TIMER_PRESCALE_EN
    localparam bit PSC_EN = 1'b1;

    timer_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((state != CNT) || !ctrl.en),
        .psc     (ctrl.psc),
        .tick_c  (tick_c)
    );
`else
    localparam bit PSC_EN = 1'b0;

    assign tick_c = 1'b1;
`endif

    // Field view of a CTRL write; PSC only stores when the prescaler is built
    always_comb begin
        wr_ctrl_c = ctrl_t'(wdata[CTRL_W-1:0]);
        if (!PSC_EN) begin
            wr_ctrl_c.psc = '0;
        end
    end

    // Next pending flag and mask; a CPU CTRL write overrides set and reload-clear
    always_comb begin
        irq_pend_nxt_c = irq_pend;
        im_nxt_c       = ctrl.im;
        if ((state == CNT) && ctrl.en && tick_c && (count <= CNT_W'(1))) begin
            irq_pend_nxt_c = 1'b1;
        end
        if ((state == INT) && auto_c) begin
            irq_pend_nxt_c = 1'b0;
        end
        if (ctrl_wr_c) begin
            irq_pend_nxt_c = 1'b0;
            im_nxt_c       = wr_ctrl_c.im;
        end
    end

    // Registers and FSM: IDLE -> LOAD -> CNT -> INT -> (LOAD | IDLE)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
            state    <= IDLE;
        end else begin
            irq_pend <= irq_pend_nxt_c;
            irq      <= irq_pend_nxt_c && im_nxt_c;

            if (ctrl_wr_c) begin
                ctrl <= wr_ctrl_c;
            end else if ((state == INT) && !auto_c) begin
                ctrl.en <= 1'b0;
            end

            if (preset_wr_c) begin
                preset <= wdata[CNT_W-1:0];
            end

            case (state)
                IDLE: begin
                    if (ctrl.en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl.en) begin
                        state <= IDLE;
                    end else if (tick_c) begin
                        if (count > CNT_W'(1)) begin
                            count <= count - CNT_W'(1);
                        end else begin
                            count <= '0;
                            state <= INT;
                        end
                    end
                end
                INT: begin
                    state <= auto_c ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency read mux, zero-extended; reserved offset reads 0
    always_comb begin
        rdata = '0;
        case (addr[3:2])
            ADDR_CTRL:   rdata = DATA_W'(ctrl);
            ADDR_PRESET: rdata = DATA_W'(preset);
            ADDR_COUNT:  rdata = DATA_W'(count);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: table vectors, hand-written corner sequences and random
// traffic checked against a behavioural model of the timer.
module tb_timer_counter;
    import timer_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        we      = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] A_CTRL = TIMER0_BASE + 32'h0;
    localparam logic [31:0] A_PRE  = TIMER0_BASE + 32'h4;
    localparam logic [31:0] A_CNT  = TIMER0_BASE + 32'h8;
    localparam logic [31:0] A_RSV  = TIMER0_BASE + 32'hC;

    timer_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: phases 0 idle, 1 load, 2 counting, 3 interrupt
    bit          m_en, m_im, m_pend, m_irq;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    int          m_ph;

    function automatic void model_reset();
        m_en = 0; m_im = 0; m_pend = 0; m_irq = 0; m_mode = 2'b00;
        m_preset = 0; m_count = 0; m_ph = 0;
    endfunction

    function automatic void model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [1:0] sel;
        sel = a[3:2];
        case (m_ph)
            0: if (m_en) m_ph = 1;
            1: begin m_count = m_preset; m_ph = 2; end
            2: begin
                if (!m_en) m_ph = 0;
                else if (m_count > 1) m_count = m_count - 1;
                else begin m_count = 0; m_pend = 1; m_ph = 3; end
            end
            default: begin
                if (m_mode == 2'b01) begin m_pend = 0; m_ph = 1; end
                else begin m_en = 0; m_ph = 0; end
            end
        endcase
        if (w && sel == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_pend = 0;
        end
        if (w && sel == 2'd1) m_preset = d;
        m_irq = m_pend & m_im;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [1:0] sel;
        sel = a[3:2];
        case (sel)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs for this cycle and let rdata settle (called at posedge+1)
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
        #1;
    endtask

    // Clock the DUT and the model with the inputs currently applied
    task automatic step_edge();
        @(posedge clk);
        model_step(we, addr, wdata);
        #1;
    endtask

    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
        drive(w, a, d);
        check("rdata", rdata, model_read(a));
        step_edge();
        check("irq", irq, 32'(m_irq));
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int k;
        bit found;

        // One-shot run with IM=1, PRESET=3, then ignored writes
        tbl[0]  = '{1'b1, A_PRE,  32'd3,          32'd0, 1'b0};
        tbl[1]  = '{1'b1, A_CTRL, 32'h9,          32'd0, 1'b0};
        tbl[2]  = '{1'b0, A_CTRL, 32'd0,          32'h9, 1'b0};
        tbl[3]  = '{1'b0, A_CNT,  32'd0,          32'd0, 1'b0};
        tbl[4]  = '{1'b0, A_CNT,  32'd0,          32'd3, 1'b0};
        tbl[5]  = '{1'b0, A_CNT,  32'd0,          32'd2, 1'b0};
        tbl[6]  = '{1'b0, A_CNT,  32'd0,          32'd1, 1'b1};
        tbl[7]  = '{1'b0, A_CNT,  32'd0,          32'd0, 1'b1};
        tbl[8]  = '{1'b0, A_CTRL, 32'd0,          32'h8, 1'b1};
        tbl[9]  = '{1'b0, A_CTRL, 32'd0,          32'h8, 1'b1};
        tbl[10] = '{1'b1, A_CTRL, 32'h8,          32'h8, 1'b0};
        tbl[11] = '{1'b0, A_CTRL, 32'd0,          32'h8, 1'b0};
        tbl[12] = '{1'b1, A_CNT,  32'h0000_FFFF,  32'd0, 1'b0};
        tbl[13] = '{1'b1, A_RSV,  32'hFFFF_FFFF,  32'd0, 1'b0};
        tbl[14] = '{1'b0, A_CNT,  32'd0,          32'd0, 1'b0};
        tbl[15] = '{1'b0, A_PRE,  32'd0,          32'd3, 1'b0};
        tbl[16] = '{1'b0, A_CTRL, 32'd0,          32'h8, 1'b0};
        tbl[17] = '{1'b0, A_RSV,  32'd0,          32'd0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_irq", irq, 0);
        check("reset_rdata", rdata, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
            step_edge();
            check($sformatf("vec%0d_irq", i), irq, 32'(tbl[i].exp_irq));
        end

        // Auto-reload, PRESET=2: one-cycle irq pulse every 4 cycles
        cyc(1'b1, A_PRE, 32'd2);
        cyc(1'b1, A_CTRL, 32'hB);
        for (int i = 1; i <= 13; i++) begin
            logic [31:0] exp_cnt;
            if (i < 3) exp_cnt = 0;
            else if ((i - 3) % 4 == 0) exp_cnt = 2;
            else if ((i - 3) % 4 == 1) exp_cnt = 1;
            else exp_cnt = 0;
            drive(1'b0, A_CNT, 32'd0);
            check("ar_count", rdata, exp_cnt);
            step_edge();
            check("ar_irq", irq, 32'((i % 4) == 0));
        end
        cyc(1'b1, A_CTRL, 32'd0);
        repeat (4) cyc(1'b0, A_CNT, 32'd0);

        // Masked interrupt: IM=0, PRESET=1
        cyc(1'b1, A_PRE, 32'd1);
        cyc(1'b1, A_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, A_CNT, 32'd0);
            check("mask_irq", irq, 0);
        end
        drive(1'b0, A_CNT, 32'd0);
        check("mask_count_end", rdata, 0);
        step_edge();

        // PRESET=0 and PRESET=1 both raise irq 3 cycles after the EN write
        for (int p = 0; p < 2; p++) begin
            cyc(1'b1, A_PRE, 32'(p));
            cyc(1'b1, A_CTRL, 32'h9);
            k = 0;
            for (int i = 1; i <= 10; i++) begin
                cyc(1'b0, A_CNT, 32'd0);
                if (irq && k == 0) k = i;
            end
            check($sformatf("latency_preset%0d", p), 32'(k), 32'd3);
            cyc(1'b1, A_CTRL, 32'd0);
            check("irq_cleared_by_ctrl", irq, 0);
        end

        // Pause at COUNT=4 with PRESET=10, then restart with a full reload
        cyc(1'b1, A_PRE, 32'd10);
        cyc(1'b1, A_CTRL, 32'h1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_ph == 2 && m_count == 5) found = 1;
            else cyc(1'b0, A_CNT, 32'd0);
        end
        check("pause_reached", 32'(found), 32'd1);
        cyc(1'b1, A_CTRL, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, A_CNT, 32'd0);
            check("pause_hold", rdata, 32'd4);
            step_edge();
        end
        cyc(1'b1, A_CTRL, 32'h1);
        cyc(1'b0, A_CNT, 32'd0);
        cyc(1'b0, A_CNT, 32'd0);
        drive(1'b0, A_CNT, 32'd0);
        check("resume_reload", rdata, 32'd10);
        step_edge();
        cyc(1'b1, A_CTRL, 32'd0);
        repeat (3) cyc(1'b0, A_CNT, 32'd0);

        // CPU CTRL write in the INT cycle wins over the one-shot EN clear
        cyc(1'b1, A_PRE, 32'd1);
        cyc(1'b1, A_CTRL, 32'h9);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_ph == 3) found = 1;
            else cyc(1'b0, A_CNT, 32'd0);
        end
        check("prio_reached_int", 32'(found), 32'd1);
        drive(1'b1, A_CTRL, 32'h9);
        step_edge();
        check("prio_irq", irq, 0);
        drive(1'b0, A_CTRL, 32'd0);
        check("prio_en_kept", rdata, 32'h9);
        step_edge();
        repeat (3) cyc(1'b0, A_CNT, 32'd0);
        cyc(1'b1, A_CTRL, 32'd0);
        repeat (3) cyc(1'b0, A_CNT, 32'd0);

        // Asynchronous reset while irq is high and registers are non-zero
        cyc(1'b1, A_PRE, 32'd5);
        cyc(1'b1, A_CTRL, 32'hB);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b0, A_CNT, 32'd0);
            if (m_irq) found = 1;
        end
        check("rst_irq_seen", 32'(found), 32'd1);
        drive(1'b0, A_CTRL, 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_async_irq", irq, 0);
        check("rst_async_ctrl", rdata, 0);
        addr = A_PRE;
        #1;
        check("rst_async_preset", rdata, 0);
        addr = A_CNT;
        #1;
        check("rst_async_count", rdata, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc(1'b1, A_PRE, 32'd2);
        repeat (3) cyc(1'b0, A_CNT, 32'd0);
        drive(1'b0, A_CNT, 32'd0);
        check("post_rst_idle_count", rdata, 0);
        step_edge();

        // Random register traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        w;
            logic [1:0]  sel;
            logic [31:0] a, d;
            w   = ($urandom_range(0, 3) == 0);
            sel = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 1) == 0) ? TIMER0_BASE : TIMER1_BASE;
            a   = a | {28'd0, sel, 2'b00};
            d   = $urandom;
            if (sel == 2'd1) d = d & 32'h7;
            cyc(w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
